// File: rtl/tmnt_palette_pipe.sv
// -----------------------------------------------------------------------------
// tmnt_palette_pipe
// Palette RAM plus final video output stage, all in the clk_sys domain.
//
// Video path: on each CE_PIX pulse the colour index, shadow and blank inputs
// are latched (S1). The cycle after the pulse (ce_d1) is the video RAM slot.
// The palette word is captured into vq on ce_d2. On the next CE_PIX it moves
// into S2 together with the S1 shadow/blank. One clk later it is expanded,
// optionally dimmed and registered onto the RGB/BLANK outputs.
//
// CPU path: byte-wide access to the 16-bit palette through a req/ack
// handshake. Requests are served only in RAM slots that video is not using.
//
// Ports
//   clk_sys, nRESET          system clock, asynchronous active-low reset
//   CE_PIX                   pixel enable pulse (>= 3 clk_sys apart)
//   CD, SHADOW, NCBLK        pixel index, active-low shadow, active-low blank
//   CPU_A, CPU_DIN           [PAL_AW:1] word address, [0]=1 low byte; write data
//   CPU_WR, CPU_RD           held requests
//   CPU_DOUT, CPU_ACK        read data (held), 1-cycle completion pulse
//   RED/GREEN/BLUE_OUT       expanded colour channels
//   BLANK_OUT                active-high blank, aligned with RGB
//   dbg_cpu_state            current CPU FSM state (0 idle, 1 access, 2 done)
// -----------------------------------------------------------------------------
module tmnt_palette_pipe #(
  parameter int CD_W        = 10,
  parameter int PAL_AW      = 11,
  parameter int CH_BITS     = 5,
  parameter int OUT_BITS    = 8,
  parameter int SHADOW_MODE = 1
) (
  input  logic                clk_sys,
  input  logic                nRESET,
  input  logic                CE_PIX,
  input  logic [CD_W-1:0]     CD,
  input  logic                SHADOW,
  input  logic                NCBLK,
  input  logic [PAL_AW:0]     CPU_A,
  input  logic [7:0]          CPU_DIN,
  input  logic                CPU_WR,
  input  logic                CPU_RD,
  output logic [7:0]          CPU_DOUT,
  output logic                CPU_ACK,
  output logic [OUT_BITS-1:0] RED_OUT,
  output logic [OUT_BITS-1:0] GREEN_OUT,
  output logic [OUT_BITS-1:0] BLUE_OUT,
  output logic                BLANK_OUT,
  output logic [1:0]          dbg_cpu_state
);

  localparam int PW = 3 * CH_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } cpu_state_t;

  // ---------------------------------------------------------------------------
  // Handshake: the CPU raises CPU_WR or CPU_RD and holds it. Exactly one
  // access is performed and CPU_ACK pulses for one cycle when it completes.
  // The CPU must drop the request before another access can start, so a
  // request held across many cycles never repeats the RAM operation.
  // ---------------------------------------------------------------------------

  cpu_state_t          cpu_state;
  logic                op_rd;
  logic                op_lo;

  logic                ce_d1, ce_d2;
  logic [CD_W-1:0]     s1_cd;
  logic                s1_shadow, s1_ncblk;
  logic [PW-1:0]       vq;
  logic [PW-1:0]       s2_col;
  logic                s2_shadow, s2_ncblk;

  logic [15:0]         mem [2**PAL_AW];
  logic [15:0]         q;
  logic [PAL_AW-1:0]   ram_addr;
  logic                cpu_go;
  logic                we_hi, we_lo;

  logic [OUT_BITS-1:0] r_px, g_px, b_px;

  assign dbg_cpu_state = cpu_state;

  // The ce_d1 slot always belongs to video; the CPU takes any other cycle.
  assign cpu_go   = (cpu_state == ST_IDLE) && (CPU_WR || CPU_RD) && !ce_d1;
  assign we_hi    = cpu_go && CPU_WR && !CPU_A[0];
  assign we_lo    = cpu_go && CPU_WR &&  CPU_A[0];
  assign ram_addr = ce_d1 ? PAL_AW'(s1_cd) : CPU_A[PAL_AW:1];

  // Palette RAM: read-before-write, no bypass, contents survive reset.
  always_ff @(posedge clk_sys) begin
    if (we_hi) mem[ram_addr][15:8] <= CPU_DIN;
    if (we_lo) mem[ram_addr][7:0]  <= CPU_DIN;
    q <= mem[ram_addr];
  end

  // MSB-first replication of a CH_BITS channel up to OUT_BITS.
  function automatic logic [OUT_BITS-1:0] expand(input logic [CH_BITS-1:0] x);
    logic [OUT_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < OUT_BITS; i++)
      r[i] = x[CH_BITS-1 - ((OUT_BITS-1-i) % CH_BITS)];
    return r;
  endfunction

  // Dimming is applied to the expanded value; both forms stay below x.
  function automatic logic [OUT_BITS-1:0] shade(input logic [OUT_BITS-1:0] v,
                                                input logic                en);
    logic [OUT_BITS-1:0] r;
    r = v;
    if (en) begin
      if (SHADOW_MODE == 1)      r = (v >> 1) + (v >> 2);
      else if (SHADOW_MODE == 2) r = v >> 1;
    end
    return r;
  endfunction

  always_comb begin
    r_px = shade(expand(s2_col[CH_BITS-1:0]),           !s2_shadow);
    g_px = shade(expand(s2_col[2*CH_BITS-1:CH_BITS]),   !s2_shadow);
    b_px = shade(expand(s2_col[3*CH_BITS-1:2*CH_BITS]), !s2_shadow);
    if (!s2_ncblk) begin
      r_px = '0;
      g_px = '0;
      b_px = '0;
    end
  end

  // Video pipeline and output registers.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      ce_d1     <= 1'b0;
      ce_d2     <= 1'b0;
      s1_cd     <= '0;
      s1_shadow <= 1'b0;
      s1_ncblk  <= 1'b0;
      vq        <= '0;
      s2_col    <= '0;
      s2_shadow <= 1'b0;
      s2_ncblk  <= 1'b0;
      RED_OUT   <= '0;
      GREEN_OUT <= '0;
      BLUE_OUT  <= '0;
      BLANK_OUT <= 1'b0;
    end else begin
      ce_d1 <= CE_PIX;
      ce_d2 <= ce_d1;
      if (CE_PIX) begin
        s1_cd     <= CD;
        s1_shadow <= SHADOW;
        s1_ncblk  <= NCBLK;
        s2_col    <= vq;
        s2_shadow <= s1_shadow;
        s2_ncblk  <= s1_ncblk;
      end
      if (ce_d2) vq <= q[PW-1:0];
      // Outputs follow S2 one clk after it loads, so RGB and blank stay aligned.
      if (ce_d1) begin
        RED_OUT   <= r_px;
        GREEN_OUT <= g_px;
        BLUE_OUT  <= b_px;
        BLANK_OUT <= !s2_ncblk;
      end
    end
  end

  // CPU access FSM. The RAM operation itself happens in the accept cycle;
  // ACCESS only collects the read data and raises the acknowledge.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      cpu_state <= ST_IDLE;
      op_rd     <= 1'b0;
      op_lo     <= 1'b0;
      CPU_DOUT  <= '0;
      CPU_ACK   <= 1'b0;
    end else begin
      CPU_ACK <= 1'b0;
      case (cpu_state)
        ST_IDLE: begin
          if (cpu_go) begin
            cpu_state <= ST_ACCESS;
            op_rd     <= CPU_RD && !CPU_WR;  // write wins when both are held
            op_lo     <= CPU_A[0];
          end
        end
        ST_ACCESS: begin
          cpu_state <= ST_DONE;
          CPU_ACK   <= 1'b1;
          if (op_rd) CPU_DOUT <= op_lo ? q[7:0] : q[15:8];
        end
        ST_DONE: begin
          if (!CPU_WR && !CPU_RD) cpu_state <= ST_IDLE;
        end
        default: cpu_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tmnt_palette_pipe.sv
// -----------------------------------------------------------------------------
// tb_tmnt_palette_pipe
// Directed bench for tmnt_palette_pipe. Three instances share every input and
// differ only in SHADOW_MODE (1, 2, 0). Expected pixel values are hand-derived
// from the palette words written; CPU read data goes through an expected queue.
// -----------------------------------------------------------------------------
module tb_tmnt_palette_pipe;

  logic        clk_sys;
  logic        nRESET;
  logic        CE_PIX;
  logic [9:0]  CD;
  logic        SHADOW;
  logic        NCBLK;
  logic [11:0] CPU_A;
  logic [7:0]  CPU_DIN;
  logic        CPU_WR;
  logic        CPU_RD;

  logic [7:0]  cpu_dout, cpu_dout_m2, cpu_dout_m0;
  logic        cpu_ack, cpu_ack_m2, cpu_ack_m0;
  logic [7:0]  red, green, blue;
  logic [7:0]  red_m2, green_m2, blue_m2;
  logic [7:0]  red_m0, green_m0, blue_m0;
  logic        blank, blank_m2, blank_m0;
  logic [1:0]  dbg_state, dbg_state_m2, dbg_state_m0;

  int          n_checks;
  int          n_fail;
  int          ack_cnt;
  int          ack_base;
  int          lat;
  logic [7:0]  exp_q[$];

  tmnt_palette_pipe #(.SHADOW_MODE(1)) dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .CE_PIX(CE_PIX), .CD(CD),
    .SHADOW(SHADOW), .NCBLK(NCBLK), .CPU_A(CPU_A), .CPU_DIN(CPU_DIN),
    .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .CPU_DOUT(cpu_dout), .CPU_ACK(cpu_ack),
    .RED_OUT(red), .GREEN_OUT(green), .BLUE_OUT(blue), .BLANK_OUT(blank),
    .dbg_cpu_state(dbg_state)
  );

  tmnt_palette_pipe #(.SHADOW_MODE(2)) dut_m2 (
    .clk_sys(clk_sys), .nRESET(nRESET), .CE_PIX(CE_PIX), .CD(CD),
    .SHADOW(SHADOW), .NCBLK(NCBLK), .CPU_A(CPU_A), .CPU_DIN(CPU_DIN),
    .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .CPU_DOUT(cpu_dout_m2), .CPU_ACK(cpu_ack_m2),
    .RED_OUT(red_m2), .GREEN_OUT(green_m2), .BLUE_OUT(blue_m2), .BLANK_OUT(blank_m2),
    .dbg_cpu_state(dbg_state_m2)
  );

  tmnt_palette_pipe #(.SHADOW_MODE(0)) dut_m0 (
    .clk_sys(clk_sys), .nRESET(nRESET), .CE_PIX(CE_PIX), .CD(CD),
    .SHADOW(SHADOW), .NCBLK(NCBLK), .CPU_A(CPU_A), .CPU_DIN(CPU_DIN),
    .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .CPU_DOUT(cpu_dout_m0), .CPU_ACK(cpu_ack_m0),
    .RED_OUT(red_m0), .GREEN_OUT(green_m0), .BLUE_OUT(blue_m0), .BLANK_OUT(blank_m0),
    .dbg_cpu_state(dbg_state_m0)
  );

  // ---------------------------------------------------------------- clock/reset
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Counts every clk_sys cycle in which the main instance drives CPU_ACK high.
  always @(posedge clk_sys) begin
    if (cpu_ack) ack_cnt <= ack_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_px(input string tag, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b,
                          input logic bl);
    check({tag, "_r"}, red, r);
    check({tag, "_g"}, green, g);
    check({tag, "_b"}, blue, b);
    check({tag, "_blank"}, blank, bl);
  endtask

  // ---------------------------------------------------------------- drivers
  // All drivers start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic pix(input logic [9:0] cd, input logic sh, input logic nb);
    CE_PIX = 1'b1;
    CD     = cd;
    SHADOW = sh;
    NCBLK  = nb;
    tick();
    CE_PIX = 1'b0;
    repeat (3) tick();
  endtask

  // Clocks until CPU_ACK is seen; lat is the number of edges since the request.
  task automatic wait_ack(output int l);
    l = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ack) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
    int l;
    CPU_A   = a;
    CPU_DIN = d;
    CPU_WR  = 1'b1;
    wait_ack(l);
    check("wr_latency", l, 2);
    CPU_WR = 1'b0;
    tick();
  endtask

  task automatic cpu_read(input logic [11:0] a, input logic [7:0] exp,
                          input int exp_lat);
    int l;
    exp_q.push_back(exp);
    CPU_A  = a;
    CPU_RD = 1'b1;
    wait_ack(l);
    check("rd_latency", l, exp_lat);
    check("rd_data", cpu_dout, exp_q.pop_front());
    CPU_RD = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    n_checks = 0;
    n_fail   = 0;
    ack_cnt  = 0;
    nRESET   = 1'b0;
    CE_PIX   = 1'b0;
    CD       = '0;
    SHADOW   = 1'b1;
    NCBLK    = 1'b0;
    CPU_A    = '0;
    CPU_DIN  = '0;
    CPU_WR   = 1'b0;
    CPU_RD   = 1'b0;

    // Reset held while CE_PIX keeps pulsing: everything stays at zero.
    tick();
    for (int i = 0; i < 3; i++) pix(10'd0, 1'b1, 1'b0);
    check_px("in_reset", 8'h00, 8'h00, 8'h00, 1'b0);
    check("in_reset_ack", cpu_ack, 0);
    check("in_reset_dout", cpu_dout, 0);
    check("in_reset_state", dbg_state, 0);

    // Release; two pulses with NCBLK low give a blanked black output.
    nRESET = 1'b1;
    tick();
    pix(10'd0, 1'b1, 1'b0);
    pix(10'd0, 1'b1, 1'b0);
    check_px("post_reset", 8'h00, 8'h00, 8'h00, 1'b1);
    check("post_reset_acks", ack_cnt, 0);

    // Palette loads: word 5 = 0x7C1F, word 7 = 0x2830, word 1023 = 0x03E0.
    cpu_write(12'h00A, 8'h7C);
    cpu_write(12'h00B, 8'h1F);
    cpu_read(12'h00A, 8'h7C, 2);
    cpu_read(12'h00B, 8'h1F, 2);
    cpu_write(12'h00E, 8'h28);
    cpu_write(12'h00F, 8'h30);
    cpu_write(12'h7FE, 8'h03);
    cpu_write(12'h7FF, 8'hE0);
    cpu_read(12'h7FF, 8'hE0, 2);
    check("load_acks", ack_cnt, 9);

    // Word 5: full red and blue, no green.
    pix(10'd5, 1'b1, 1'b1);
    pix(10'd5, 1'b1, 1'b1);
    check_px("w5_plain", 8'hFF, 8'h00, 8'hFF, 1'b0);

    // Same pixel shadowed in each dimming mode.
    pix(10'd5, 1'b0, 1'b1);
    pix(10'd5, 1'b0, 1'b1);
    check_px("w5_shadow_m1", 8'hBE, 8'h00, 8'hBE, 1'b0);
    check("w5_shadow_m2_r", red_m2, 8'h7F);
    check("w5_shadow_m2_b", blue_m2, 8'h7F);
    check("w5_shadow_m0_r", red_m0, 8'hFF);
    check("w5_shadow_m0_b", blue_m0, 8'hFF);

    // Word 7: mixed channel values, plain then shadowed.
    pix(10'd7, 1'b1, 1'b1);
    pix(10'd7, 1'b0, 1'b1);
    check_px("w7_plain", 8'h84, 8'h08, 8'h52, 1'b0);
    pix(10'd7, 1'b0, 1'b1);
    check_px("w7_shadow_m1", 8'h63, 8'h06, 8'h3D, 1'b0);
    check("w7_shadow_m2_g", green_m2, 8'h04);
    check("w7_shadow_m2_b", blue_m2, 8'h29);
    check("w7_shadow_m0_r", red_m0, 8'h84);

    // Highest index: pure green, then blanked.
    pix(10'd1023, 1'b1, 1'b1);
    pix(10'd1023, 1'b1, 1'b0);
    check_px("w1023_plain", 8'h00, 8'hFF, 8'h00, 1'b0);
    pix(10'd1023, 1'b1, 1'b1);
    check_px("w1023_blank", 8'h00, 8'h00, 8'h00, 1'b1);
    check("w1023_blank_m2", blank_m2, 1'b1);

    // Read raised in the video slot: served one clk late, video unaffected.
    CE_PIX = 1'b1;
    CD     = 10'd7;
    SHADOW = 1'b1;
    NCBLK  = 1'b1;
    tick();
    CE_PIX = 1'b0;
    exp_q.push_back(8'h7C);
    CPU_A  = 12'h00A;
    CPU_RD = 1'b1;
    wait_ack(lat);
    check("slot_rd_latency", lat, 3);
    check("slot_rd_data", cpu_dout, exp_q.pop_front());
    CPU_RD = 1'b0;
    tick();
    pix(10'd7, 1'b1, 1'b1);
    check_px("slot_video", 8'h84, 8'h08, 8'h52, 1'b0);

    // Both requests high act as a write and leave CPU_DOUT alone.
    CPU_A   = 12'h012;
    CPU_DIN = 8'h11;
    CPU_WR  = 1'b1;
    CPU_RD  = 1'b1;
    wait_ack(lat);
    check("both_latency", lat, 2);
    check("both_dout_kept", cpu_dout, 8'h7C);
    CPU_WR = 1'b0;
    CPU_RD = 1'b0;
    tick();
    cpu_read(12'h012, 8'h11, 2);

    // Write held for 10 clk: one ACK, one RAM write (data changed after ACK).
    ack_base = ack_cnt;
    CPU_A    = 12'h013;
    CPU_DIN  = 8'h55;
    CPU_WR   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (cpu_ack) CPU_DIN = 8'hAA;
    end
    check("held_state_done", dbg_state, 2);
    CPU_WR = 1'b0;
    repeat (2) tick();
    check("held_ack_count", ack_cnt - ack_base, 1);
    cpu_read(12'h013, 8'h55, 2);

    // Reset asserted while in ACCESS: no ACK, FSM back to IDLE, write kept.
    ack_base = ack_cnt;
    CPU_A    = 12'h012;
    CPU_DIN  = 8'h66;
    CPU_WR   = 1'b1;
    tick();
    check("mid_state_access", dbg_state, 1);
    nRESET = 1'b0;
    #1;
    check("mid_reset_state", dbg_state, 0);
    check("mid_reset_ack", cpu_ack, 0);
    CPU_WR = 1'b0;
    @(posedge clk_sys);
    #1;
    tick();
    check("mid_reset_no_ack", ack_cnt - ack_base, 0);
    nRESET = 1'b1;
    tick();
    cpu_read(12'h012, 8'h66, 2);
    cpu_read(12'h013, 8'h55, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
